// File: rtl/fadd_normalise_stage_pkg.sv
// Shared constants and result bundle for the half-precision adder
// normalise-and-pack stage.
package fadd_normalise_stage_pkg;

    localparam int EXP_W      = 5;
    localparam int MANT_W     = 11;
    localparam int FRAC_W     = MANT_W - 1;
    localparam int SUM_W      = MANT_W + 1;
    localparam int SH_W       = 4;
    localparam int FLG_W      = 3;
    localparam int FLG_ZERO   = 0;
    localparam int FLG_UF     = 1;
    localparam int FLG_OVF    = 2;
    localparam int MAX_NSHIFT = 10;

    localparam logic [EXP_W-1:0] EXP_INF = 5'd31;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [FLG_W-1:0]  flags;
    } norm_res_t;

    // Out-of-range shift counts saturate at the widest legal shift.
    function automatic logic [SH_W-1:0] clamp_shift(
        input logic [EXP_W-1:0] sh
    );
        logic [SH_W-1:0] r;
        if (sh > EXP_W'(MAX_NSHIFT))
            r = SH_W'(MAX_NSHIFT);
        else
            r = sh[SH_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fadd_normalise_stage_norm_barrel_shift.sv
// Combinational significand shifter: left by 0..10, or right by one
// when the sum carried out.
module norm_barrel_shift
    import fadd_normalise_stage_pkg::*;
(
    input  logic [SUM_W-1:0]  sum,
    input  logic [SH_W-1:0]   amount,
    input  logic              right,
    output logic [MANT_W-1:0] result
);

    always_comb begin
        if (right)
            result = sum[SUM_W-1:1];
        else
            result = sum[MANT_W-1:0] << amount;
    end

endmodule

// File: rtl/fadd_normalise_stage.sv
// Normalise-and-pack stage with two-entry valid/ready pipeline.
// Subnormal output is enabled by defining FADD_NORM_DENORMAL_EN.
module fadd_normalise_stage
    import fadd_normalise_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [SUM_W-1:0]  in_mant,
    input  logic [EXP_W-1:0]  in_normshift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic [FLG_W-1:0]  out_flags,
    output logic [FLG_W-1:0]  sticky_flags,
    input  logic              clear_sticky
);

    logic              a_valid;
    norm_res_t         a_res;
    norm_res_t         nxt;
    logic              a_adv;
    logic              out_xfer;
    logic              carry;
    logic              is_inf;
    logic              is_zero;
    logic              is_norm;
    logic [SH_W-1:0]   nsh;
    logic [SH_W-1:0]   sh_amt;
    logic [EXP_W:0]    exp_inc;
    logic [EXP_W:0]    exp_sub;
    logic [MANT_W-1:0] shifted;
    logic              unused_bits;

    assign out_xfer = out_valid & out_ready;
    assign a_adv    = a_valid & (!out_valid | out_ready);
    assign in_ready = !a_valid | a_adv;

    assign nsh     = clamp_shift(in_normshift);
    assign carry   = in_mant[SUM_W-1];
    assign is_inf  = (in_exp == EXP_INF);
    assign is_zero = (in_mant == '0);
    assign is_norm = ({1'b0, in_exp} > {2'b0, nsh});
    assign exp_inc = {1'b0, in_exp} + 6'd1;
    assign exp_sub = {1'b0, in_exp} - {2'b0, nsh};

`ifdef FADD_NORM_DENORMAL_EN
    // Underflow only reaches here with in_exp <= 10, so the cast is safe.
    assign sh_amt = is_norm ? nsh :
                    (in_exp == '0) ? '0 :
                    SH_W'(in_exp - 5'd1);
`else
    assign sh_amt = nsh;
`endif

    norm_barrel_shift u_shift (
        .sum    (in_mant),
        .amount (sh_amt),
        .right  (carry),
        .result (shifted)
    );

    assign unused_bits = ^{shifted[MANT_W-1], exp_sub[EXP_W]};

    always_comb begin
        nxt      = '0;
        nxt.sign = in_sign;
        priority case (1'b1)
            carry: begin
                if (exp_inc >= {1'b0, EXP_INF}) begin
                    nxt.exp            = EXP_INF;
                    nxt.flags[FLG_OVF] = 1'b1;
                end else begin
                    nxt.exp  = exp_inc[EXP_W-1:0];
                    nxt.frac = shifted[FRAC_W-1:0];
                end
            end
            is_inf: begin
                nxt.exp            = EXP_INF;
                nxt.flags[FLG_OVF] = 1'b1;
            end
            is_zero: begin
                nxt.flags[FLG_ZERO] = 1'b1;
            end
            is_norm: begin
                nxt.exp  = exp_sub[EXP_W-1:0];
                nxt.frac = shifted[FRAC_W-1:0];
            end
            default: begin
`ifdef FADD_NORM_DENORMAL_EN
                nxt.frac = shifted[FRAC_W-1:0];
                if (shifted[FRAC_W-1:0] == '0) begin
                    nxt.flags[FLG_UF]   = 1'b1;
                    nxt.flags[FLG_ZERO] = 1'b1;
                end
`else
                nxt.flags[FLG_UF]   = 1'b1;
                nxt.flags[FLG_ZERO] = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_res   <= '0;
        end else if (in_valid && in_ready) begin
            a_valid <= 1'b1;
            a_res   <= nxt;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    // Output data only moves when a new item lands, so a stalled
    // result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_flags <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid <= a_valid;
            if (a_valid)
                {out_sign, out_exp, out_frac, out_flags} <= a_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sticky_flags <= '0;
        else if (clear_sticky)
            sticky_flags <= '0;
        else if (out_xfer)
            sticky_flags <= sticky_flags | out_flags;
    end

endmodule

// File: tb/tb_fadd_normalise_stage.sv
// Directed and randomized bench for fadd_normalise_stage with an
// arithmetic reference model and an in-order scoreboard.
module tb_fadd_normalise_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic [11:0] in_mant = '0;
    logic [4:0]  in_normshift = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [4:0]  out_exp;
    logic [9:0]  out_frac;
    logic [2:0]  out_flags;
    logic [2:0]  sticky_flags;
    logic        clear_sticky = 1'b0;

    int checks = 0;
    int passes = 0;
    int out_cnt = 0;
    int idx_clr = 0;
    int base = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];

    always #5 clk = ~clk;

    fadd_normalise_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_normshift (in_normshift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_frac     (out_frac),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky)
    );

    // Value-level model: {sign, exp, frac, {ovf, uf, zero}}.
    function automatic logic [18:0] model(input logic s, input int e,
                                          input int m, input int ns);
        int eo = 0;
        int f = 0;
        int sh;
        logic [2:0] fl = 3'b000;
        if (ns > 10) ns = 10;
        if (m >= 2048) begin
            eo = e + 1;
            if (eo >= 31) begin
                eo = 31;
                fl = 3'b100;
            end else begin
                f = (m / 2) % 1024;
            end
        end else if (e == 31) begin
            eo = 31;
            fl = 3'b100;
        end else if (m == 0) begin
            fl = 3'b001;
        end else if (e > ns) begin
            eo = e - ns;
            f = (m * (1 << ns)) % 1024;
        end else begin
`ifdef FADD_NORM_DENORMAL_EN
            sh = (e > 0) ? e - 1 : 0;
            f = (m * (1 << sh)) % 1024;
            if (f == 0) fl = 3'b011;
`else
            sh = 0;
            fl = 3'b011;
`endif
        end
        return {s, 5'(eo), 10'(f), fl};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign, int'(in_exp),
                                      int'(in_mant), int'(in_normshift)));
            if (out_valid && out_ready) begin
                obs_q.push_back({out_sign, out_exp, out_frac, out_flags});
                out_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic [4:0] e,
                          input logic [11:0] m, input logic [4:0] ns);
        in_valid = 1'b1;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        in_normshift = ns;
    endtask

    task automatic send(input logic s, input logic [4:0] e,
                        input logic [11:0] m, input logic [4:0] ns);
        int n = 0;
        set_in(s, e, m, ns);
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        chk("send_accept", 32'(in_ready), 32'd1);
        sync();
    endtask

    task automatic directed(input string tag, input logic s,
                            input logic [4:0] e, input logic [11:0] m,
                            input logic [4:0] ns, input logic [4:0] xe,
                            input logic [9:0] xf, input logic [2:0] xfl);
        int n = 0;
        send(s, e, m, ns);
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_sign"}, 32'(out_sign), 32'(s));
        chk({tag, "_exp"}, 32'(out_exp), 32'(xe));
        chk({tag, "_frac"}, 32'(out_frac), 32'(xf));
        chk({tag, "_flags"}, 32'(out_flags), 32'(xfl));
        sync();
    endtask

    initial begin
        logic [2:0] xs;
        repeat (3) sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_out_frac", 32'(out_frac), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        sync();

        directed("normal", 1'b0, 5'd15, 12'b0_00100000000, 5'd2,
                 5'd13, 10'd0, 3'b000);
        directed("carry", 1'b1, 5'd15, 12'b1_00000000010, 5'd0,
                 5'd16, 10'b0000000001, 3'b000);
        directed("carry_ovf", 1'b0, 5'd30, 12'b1_00000000010, 5'd0,
                 5'd31, 10'd0, 3'b100);
        chk("sticky_ovf", 32'(sticky_flags), 32'b100);
        directed("zero", 1'b0, 5'd20, 12'd0, 5'd7,
                 5'd0, 10'd0, 3'b001);
        directed("clamp", 1'b0, 5'd15, 12'b0_00000000001, 5'd13,
                 5'd5, 10'd0, 3'b000);
        directed("inf", 1'b1, 5'd31, 12'b0_10000000000, 5'd0,
                 5'd31, 10'd0, 3'b100);
`ifdef FADD_NORM_DENORMAL_EN
        directed("uflow", 1'b0, 5'd5, 12'b0_00000000001, 5'd10,
                 5'd0, 10'b0000010000, 3'b000);
        directed("uflow_eq", 1'b0, 5'd2, 12'b0_00100000000, 5'd2,
                 5'd0, 10'b1000000000, 3'b000);
`else
        directed("uflow", 1'b0, 5'd5, 12'b0_00000000001, 5'd10,
                 5'd0, 10'd0, 3'b011);
        directed("uflow_eq", 1'b0, 5'd2, 12'b0_00100000000, 5'd2,
                 5'd0, 10'd0, 3'b011);
`endif
        chk("sticky_any", 32'(sticky_flags[0] & sticky_flags[2]), 32'd1);

        // Clear lands on the same edge as a zero-flag transfer.
        set_in(1'b0, 5'd9, 12'd0, 5'd0);
        sync();
        in_valid = 1'b0;
        sync();
        clear_sticky = 1'b1;
        sync();
        clear_sticky = 1'b0;
        chk("clear_prio", 32'(sticky_flags), 32'd0);
        idx_clr = exp_q.size();

        set_in(1'b0, 5'd15, 12'b0_00100000000, 5'd2);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        sync();
        set_in(1'b1, 5'd10, 12'b0_01000000000, 5'd1);
        @(negedge clk);
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        sync();
        set_in(1'b0, 5'd20, 12'd0, 5'd3);
        @(negedge clk);
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'({out_sign, out_exp, out_frac, out_flags}),
            32'(model(1'b0, 15, 256, 2)));
        sync();
        @(negedge clk);
        chk("bp_full2", 32'(in_ready), 32'd0);
        chk("bp_hold2", 32'({out_sign, out_exp, out_frac, out_flags}),
            32'(model(1'b0, 15, 256, 2)));
        sync();
        out_ready = 1'b1;
        base = out_cnt;
        send(1'b0, 5'd20, 12'd0, 5'd3);
        send(1'b1, 5'd30, 12'b1_11111111111, 5'd0);
        in_valid = 1'b0;
        sync();
        sync();
        chk("bp_drain_cnt", 32'(out_cnt - base), 32'd4);
        chk("bp_drain_empty", 32'(out_valid), 32'd0);

        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sign = 1'($urandom);
            in_exp = 5'($urandom_range(0, 31));
            in_normshift = 5'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: begin
                    in_mant = '0;
                    in_exp = 5'($urandom_range(0, 30));
                end
                1: in_mant = {1'b1, 11'($urandom)};
                default: in_mant = {1'b0,
                    11'($urandom) >> $urandom_range(0, 10)};
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            sync();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) sync();

        chk("sb_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("sb_item", 32'(obs_q[i]), 32'(exp_q[i]));
        xs = 3'b000;
        for (int i = idx_clr; i < exp_q.size(); i++)
            xs = xs | exp_q[i][2:0];
        chk("sticky_accum", 32'(sticky_flags), 32'(xs));

        out_ready = 1'b0;
        set_in(1'b0, 5'd12, 12'b0_10000000000, 5'd0);
        sync();
        set_in(1'b0, 5'd3, 12'd0, 5'd0);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full", 32'({out_valid, in_ready}), 32'b10);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        base = out_cnt;
        repeat (3) sync();
        chk("mid_rst_discard", 32'(out_cnt - base), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
